// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide RAM port between instruction fetch and the MEM stage (MEM wins ties).
// Read takes len+1 busy cycles and a write takes len, then one DONE cycle; requests that lose or arrive while busy wait, seeing IDLE.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_data,
    output logic [1:0]        if_status,
    input  logic [1:0]        rw_mem,
    input  logic [ADDR_W-1:0] addr_to_mem,
    input  logic [31:0]       data_to_mem,
    input  logic [3:0]        quantity,
    output logic [31:0]       data_from_mem,
    output logic [1:0]        mem_status,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       data_from_mem_q, data_from_mem_d;

    logic              mem_ok;
    logic [31:0]       rbuf_masked;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            owner_q         <= 1'b0;
            base_q          <= '0;
            cnt_q           <= 3'd0;
            len_q           <= 3'd0;
            wdata_q         <= 32'd0;
            rbuf_q          <= 32'd0;
            if_data_q       <= 32'd0;
            data_from_mem_q <= 32'd0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            base_q          <= base_d;
            cnt_q           <= cnt_d;
            len_q           <= len_d;
            wdata_q         <= wdata_d;
            rbuf_q          <= rbuf_d;
            if_data_q       <= if_data_d;
            data_from_mem_q <= data_from_mem_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        base_d          = base_q;
        cnt_d           = cnt_q;
        len_d           = len_q;
        wdata_d         = wdata_q;
        rbuf_d          = rbuf_q;
        if_data_d       = if_data_q;
        data_from_mem_d = data_from_mem_q;
        ram_a           = '0;
        ram_dout        = 8'd0;
        ram_wr          = 1'b0;
        if_status       = ST_IDLE;
        mem_status      = ST_IDLE;

        mem_ok = ((rw_mem == 2'b01) || (rw_mem == 2'b10)) &&
                 ((quantity == 4'd1) || (quantity == 4'd2) || (quantity == 4'd4));

        // Bytes beyond the transfer length may hold stale data from an earlier read.
        rbuf_masked = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < len_q) begin
                rbuf_masked[8*k +: 8] = rbuf_q[8*k +: 8];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (mem_ok) begin
                    owner_d = 1'b1;
                    base_d  = addr_to_mem;
                    len_d   = quantity[2:0];
                    wdata_d = data_to_mem;
                    cnt_d   = 3'd0;
                    state_d = (rw_mem == 2'b10) ? S_WRITE : S_READ;
                end else if (if_req && !if_flush) begin
                    owner_d = 1'b0;
                    base_d  = if_addr;
                    len_d   = 3'd4;
                    wdata_d = data_to_mem;
                    cnt_d   = 3'd0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (owner_q) mem_status = ST_BUSY;
                else         if_status  = ST_BUSY;
                if (cnt_q < len_q) begin
                    ram_a = base_q + ADDR_W'(cnt_q);
                end
                // RAM data lags the address by one cycle, so byte cnt-1 arrives now.
                if (cnt_q != 3'd0) begin
                    rbuf_d[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = ram_din;
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == len_q) begin
                    state_d = S_DONE;
                end
                if (!owner_q && if_flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (owner_q) mem_status = ST_BUSY;
                else         if_status  = ST_BUSY;
                ram_a    = base_q + ADDR_W'(cnt_q);
                ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                ram_wr   = 1'b1;
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == len_q - 3'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (owner_q) begin
                    mem_status      = ST_DONE;
                    data_from_mem_d = rbuf_masked;
                end else if (!if_flush) begin
                    if_status = ST_DONE;
                    if_data_d = rbuf_masked;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reset must silence the RAM port immediately, not at the next edge.
        if (rst) begin
            ram_a      = '0;
            ram_dout   = 8'd0;
            ram_wr     = 1'b0;
            if_status  = ST_IDLE;
            mem_status = ST_IDLE;
        end
        if_data       = rst ? 32'd0 : if_data_d;
        data_from_mem = rst ? 32'd0 : data_from_mem_d;
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte RAM model, expectation queues fed by the stimulus, and a negedge monitor.
module tb_mem_ctrl;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_data;
    logic [1:0]  if_status;
    logic [1:0]  rw_mem;
    logic [31:0] addr_to_mem;
    logic [31:0] data_to_mem;
    logic [3:0]  quantity;
    logic [31:0] data_from_mem;
    logic [1:0]  mem_status;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_data(if_data), .if_status(if_status),
        .rw_mem(rw_mem), .addr_to_mem(addr_to_mem), .data_to_mem(data_to_mem),
        .quantity(quantity), .data_from_mem(data_from_mem), .mem_status(mem_status),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    typedef struct {
        logic [31:0] data;
        int          busy;
        logic [31:0] base;
        int          len;
        bit          rd;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t exp_if[$];
    exp_t exp_mem[$];
    wr_t  exp_wr[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] ram_m [logic [31:0]];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // RAM model: address and write strobe taken at the edge, read byte presented shortly after.
    logic [31:0] ram_la;
    logic        ram_lw;
    logic [7:0]  ram_ld;
    always @(posedge clk) begin
        ram_la = ram_a;
        ram_lw = ram_wr;
        ram_ld = ram_dout;
        if (ram_lw) ram_m[ram_la] = ram_ld;
        #1;
        ram_din = ram_m.exists(ram_la) ? ram_m[ram_la] : 8'h00;
    end

    // Monitor
    int          busy_n [2];
    logic [31:0] alog [2][8];
    logic [1:0]  mst;
    logic [31:0] mdat;
    exp_t        me;
    wr_t         mw;
    bit          have;
    int          bad_i;
    always @(negedge clk) begin
        if (rst) begin
            busy_n[0] = 0;
            busy_n[1] = 0;
        end else begin
            if (ram_wr) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_wr", ram_wr, 1'b0);
                end else begin
                    mw = exp_wr.pop_front();
                    chk("wr_addr", ram_a, mw.a);
                    chk("wr_byte", ram_dout, mw.d);
                end
            end
            for (int p = 0; p < 2; p++) begin
                mst  = (p == 1) ? mem_status : if_status;
                mdat = (p == 1) ? data_from_mem : if_data;
                if (mst == BUSY) begin
                    if (busy_n[p] < 8) alog[p][busy_n[p]] = ram_a;
                    busy_n[p]++;
                end else begin
                    if (mst == DONE) begin
                        have = (p == 1) ? (exp_mem.size() != 0) : (exp_if.size() != 0);
                        if (!have) begin
                            chk((p == 1) ? "unexpected_mem_done" : "unexpected_if_done", mst, IDLE);
                        end else begin
                            if (p == 1) me = exp_mem.pop_front();
                            else        me = exp_if.pop_front();
                            chk((p == 1) ? "mem_busy_cycles" : "if_busy_cycles", busy_n[p], me.busy);
                            if (me.rd) begin
                                chk((p == 1) ? "data_from_mem" : "if_data", mdat, me.data);
                                bad_i = -1;
                                for (int i = 0; i < me.len; i++) begin
                                    if (bad_i < 0 && (i >= busy_n[p] || alog[p][i] !== me.base + 32'(i)))
                                        bad_i = i;
                                end
                                chk("rd_addr_first_bad_index", bad_i, -1);
                            end
                        end
                    end
                    busy_n[p] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int p);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (((p == 1) ? mem_status : if_status) == DONE) done = 1'b1;
            else tick();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for DONE on port %0d", p);
        end
    endtask

    task automatic load4(input logic [31:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) ram_m[a + 32'(k)] = w[8*k +: 8];
    endtask

    task automatic mem_op(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] q, input logic [31:0] exp_d);
        exp_t e;
        wr_t  w;
        e.data = exp_d;
        e.len  = int'(q);
        e.base = a;
        e.rd   = (rw == 2'b01);
        e.busy = e.rd ? e.len + 1 : e.len;
        if (!e.rd) begin
            for (int k = 0; k < e.len; k++) begin
                w.a = a + 32'(k);
                w.d = d[8*k +: 8];
                exp_wr.push_back(w);
            end
        end
        exp_mem.push_back(e);
        rw_mem = rw; addr_to_mem = a; data_to_mem = d; quantity = q;
        tick();
        rw_mem = 2'b00;
        wait_done(1);
        tick();
    endtask

    task automatic fetch_op(input logic [31:0] a, input logic [31:0] exp_d);
        exp_t e;
        e.data = exp_d; e.len = 4; e.base = a; e.rd = 1'b1; e.busy = 5;
        exp_if.push_back(e);
        if_req = 1'b1; if_addr = a;
        tick();
        if_req = 1'b0;
        wait_done(0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        exp_t e;
        wr_t  w;
        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
        rw_mem = 2'b00; addr_to_mem = 32'd0; data_to_mem = 32'd0; quantity = 4'd0;
        ram_din = 8'd0;
        tick();
        tick();
        chk("rst_if_status", if_status, IDLE);
        chk("rst_mem_status", mem_status, IDLE);
        chk("rst_ram_wr", ram_wr, 1'b0);
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_dout", ram_dout, 8'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_data_from_mem", data_from_mem, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ram_a", ram_a, 32'd0);
        chk("idle_mem_status", mem_status, IDLE);

        // 4-byte load
        load4(32'h100, 32'h44332211);
        mem_op(2'b01, 32'h100, 32'd0, 4'd4, 32'h44332211);

        // stores of 1 and 4 bytes, then read the word back
        mem_op(2'b10, 32'h200, 32'h123456AB, 4'd1, 32'd0);
        mem_op(2'b10, 32'h204, 32'hDEADBEEF, 4'd4, 32'd0);
        mem_op(2'b01, 32'h204, 32'd0, 4'd4, 32'hDEADBEEF);
        chk("data_from_mem_hold", data_from_mem, 32'hDEADBEEF);

        // simultaneous fetch and load: load first, fetch waits with IDLE
        load4(32'h0, 32'h04030201);
        load4(32'h40, 32'h43424140);
        e.data = 32'h43424140; e.busy = 5; e.base = 32'h40; e.len = 4; e.rd = 1'b1;
        exp_mem.push_back(e);
        e.data = 32'h04030201; e.busy = 5; e.base = 32'h0;  e.len = 4; e.rd = 1'b1;
        exp_if.push_back(e);
        if_req = 1'b1; if_addr = 32'h0;
        rw_mem = 2'b01; addr_to_mem = 32'h40; quantity = 4'd4;
        tick();
        rw_mem = 2'b00;
        for (int i = 0; i < 6; i++) begin
            chk("if_wait_idle", if_status, IDLE);
            if (i < 5) tick();
        end
        chk("mem_done_first", mem_status, DONE);
        tick();
        chk("if_pending_idle", if_status, IDLE);
        tick();
        if_req = 1'b0;
        wait_done(0);
        tick();

        // flushed fetch, then a normal fetch
        load4(32'h10, 32'h99887766);
        load4(32'h80, 32'hD3C2B1A0);
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        if_req = 1'b0;
        tick();
        tick();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        chk("flush_if_status", if_status, IDLE);
        chk("flush_mem_status", mem_status, IDLE);
        chk("flush_ram_a", ram_a, 32'd0);
        chk("flush_if_data_kept", if_data, 32'h04030201);
        repeat (3) tick();
        fetch_op(32'h80, 32'hD3C2B1A0);

        // 2-byte unaligned load with stale upper bytes, then illegal quantities
        ram_m[32'h301] = 8'hAA;
        ram_m[32'h302] = 8'hBB;
        mem_op(2'b01, 32'h301, 32'd0, 4'd2, 32'h0000BBAA);
        for (int j = 0; j < 2; j++) begin
            rw_mem = 2'b01; addr_to_mem = 32'h300; quantity = (j == 0) ? 4'd0 : 4'd3;
            repeat (4) begin
                tick();
                chk("illegal_q_status", mem_status, IDLE);
                chk("illegal_q_ram_a", ram_a, 32'd0);
            end
        end
        rw_mem = 2'b00;
        tick();

        // reset during a 4-byte store: only byte 0 lands
        w.a = 32'h500; w.d = 8'h0D;
        exp_wr.push_back(w);
        rw_mem = 2'b10; addr_to_mem = 32'h500; data_to_mem = 32'h0A0B0C0D; quantity = 4'd4;
        tick();
        rw_mem = 2'b00;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_ram_wr", ram_wr, 1'b0);
        chk("midrst_ram_a", ram_a, 32'd0);
        chk("midrst_ram_dout", ram_dout, 8'd0);
        chk("midrst_mem_status", mem_status, IDLE);
        chk("midrst_if_status", if_status, IDLE);
        chk("midrst_if_data", if_data, 32'd0);
        chk("midrst_data_from_mem", data_from_mem, 32'd0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("postrst_mem_status", mem_status, IDLE);
        chk("postrst_byte1_written", ram_m.exists(32'h501), 1'b0);

        chk("exp_wr_left", exp_wr.size(), 0);
        chk("exp_mem_left", exp_mem.size(), 0);
        chk("exp_if_left", exp_if.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
